// File: rtl/sprite_fetch.sv
// sprite_fetch: overlays a PIC_H x PIC_V sprite, read from a synchronous image
// ROM (1-cycle read latency), onto a flat background colour.
// - The sprite position is latched once per frame, at the last visible pixel.
// - Syncs and valid are delayed one clock so they stay aligned with pixel data.
// Optional build macro FETCH_CHECK_EN: enables the sticky fetch-sequencing
// error flag on err. Without the macro, err is tied low.
module sprite_fetch #(
  parameter int          H_SIZE   = 640,
  parameter int          V_SIZE   = 480,
  parameter int          PIC_H    = 100,
  parameter int          PIC_V    = 100,
  parameter logic [23:0] BG_COLOR = 24'hFFEEDD,
  localparam int         HW       = $clog2(H_SIZE),
  localparam int         VW       = $clog2(V_SIZE),
  localparam int         PIC_SIZE = PIC_H * PIC_V,
  localparam int         AW       = $clog2(PIC_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [HW-1:0] h_addr,
  input  logic [VW-1:0] v_addr,
  input  logic          valid,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [HW-1:0] pos_x,
  input  logic [VW-1:0] pos_y,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [23:0]   rom_data,
  output logic [23:0]   pix_data,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          valid_out,
  output logic          frame_done,
  output logic          err
);

  // Fetch sequencing states.
  //   WAIT_FRAME : after reset; no reads until the first frame boundary
  //   SCAN       : sprite window active, reading ROM words in raster order
  //   DONE       : all PIC_SIZE words read this frame; reads suppressed
  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SCAN       = 2'd1,
    DONE       = 2'd2
  } state_t;

  // Widened by one bit so cur+PIC never overflows and the clamp compares cleanly.
  localparam logic [HW:0]   X_MAX     = (HW+1)'(H_SIZE - PIC_H);
  localparam logic [VW:0]   Y_MAX     = (VW+1)'(V_SIZE - PIC_V);
  localparam logic [HW:0]   PIC_H_W   = (HW+1)'(PIC_H);
  localparam logic [VW:0]   PIC_V_W   = (VW+1)'(PIC_V);
  localparam logic [HW-1:0] X_LAST    = HW'(H_SIZE - 1);
  localparam logic [VW-1:0] Y_LAST    = VW'(V_SIZE - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(PIC_SIZE - 1);
  localparam logic [HW-1:0] X_RST     = HW'((H_SIZE - PIC_H) / 2);
  localparam logic [VW-1:0] Y_RST     = VW'((V_SIZE - PIC_V) / 2);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [HW-1:0]   cur_x_q, cur_x_d;
  logic [VW-1:0]   cur_y_q, cur_y_d;
  logic            hsync_q, vsync_q, valid_q, sel_q, frame_done_q;

  logic            frame_end;
  logic            in_win;
  logic            fetch;
  logic [HW:0]     h_ext, cx_ext, px_ext;
  logic [VW:0]     v_ext, cy_ext, py_ext;

  assign h_ext  = {1'b0, h_addr};
  assign v_ext  = {1'b0, v_addr};
  assign cx_ext = {1'b0, cur_x_q};
  assign cy_ext = {1'b0, cur_y_q};
  assign px_ext = {1'b0, pos_x};
  assign py_ext = {1'b0, pos_y};

  assign frame_end = valid && (h_addr == X_LAST) && (v_addr == Y_LAST);

  assign in_win = valid
               && (h_ext >= cx_ext) && (h_ext < cx_ext + PIC_H_W)
               && (v_ext >= cy_ext) && (v_ext < cy_ext + PIC_V_W);

  assign fetch    = in_win && (state_q == SCAN);
  assign rom_en   = fetch;
  assign rom_addr = addr_q;

  // Next sprite position: clamped so the whole sprite always fits on screen.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (frame_end) begin
      cur_x_d = (px_ext > X_MAX) ? X_MAX[HW-1:0] : pos_x;
      cur_y_d = (py_ext > Y_MAX) ? Y_MAX[VW-1:0] : pos_y;
    end
  end

  // Fetch FSM next-state and address counter; frame_end overrides everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      WAIT_FRAME: ;
      SCAN: begin
        if (fetch) begin
          if (addr_q == ADDR_LAST) begin
            state_d = DONE;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DONE: ;
      default: state_d = WAIT_FRAME;
    endcase
    // A new frame always restarts the fetch, even if the previous one was cut short.
    if (frame_end) begin
      state_d = SCAN;
      addr_d  = '0;
    end
  end

  // FSM state, address counter and latched sprite position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_FRAME;
      addr_q  <= '0;
      cur_x_q <= X_RST;
      cur_y_q <= Y_RST;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
    end
  end

  // One-clock output pipeline matching the ROM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      valid_q      <= 1'b0;
      sel_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      hsync_q      <= hsync_in;
      vsync_q      <= vsync_in;
      valid_q      <= valid;
      sel_q        <= fetch;
      frame_done_q <= frame_end;
    end
  end

  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign valid_out  = valid_q;
  assign frame_done = frame_done_q;

  // ROM word is only on the bus the cycle after its read, so select on sel_q.
  always_comb begin
    pix_data = 24'h000000;
    if (valid_q) begin
      pix_data = sel_q ? rom_data : BG_COLOR;
    end
  end

`ifdef FETCH_CHECK_EN
  logic err_q;

  // Sticky error: frame ended mid-fetch, or the window was reached after all reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((frame_end && state_q == SCAN) || (in_win && state_q == DONE)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
